// File: rtl/pipeline_controller_pkg.sv
// Shared types for the NAND CPU pipeline controller and the stage glue.
//   ctrl_state_e : sequencing state of the controller
//   pipe_ctrl_t  : the six per-stage stall/flush/bubble bits, bundled so the
//                  glue circuits can consume them as one value
package pipeline_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic fetch_stall;
    logic dec_stall;
    logic dec_bubble;
    logic act_stall;
    logic flush_fetch;
    logic flush_dec;
  } pipe_ctrl_t;

  // Everything quiet: the pipeline advances normally.
  localparam pipe_ctrl_t CTRL_IDLE = '0;

  // Freeze fetch, decode and action together (d-cache wait or error halt).
  function automatic pipe_ctrl_t ctrl_hold_all();
    pipe_ctrl_t c;
    c = CTRL_IDLE;
    c.fetch_stall = 1'b1;
    c.dec_stall   = 1'b1;
    c.act_stall   = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Handshake bundle between the pipeline stage glue and the controller.
//   master modport : stage glue side, drives decode/action/d-cache status,
//                    receives stall/flush/bubble controls and status
//   slave modport  : controller side
// Status in : dec_valid, dec_ra_read, dec_rt_read, dec_ra_addr, dec_rt_addr,
//             dec_ps_read, act_valid, act_reg_write, act_reg_addr,
//             act_ps_write, act_mem_access, act_branch_taken, dc_miss, dc_done
// Controls  : fetch_stall, dec_stall, dec_bubble, act_stall, flush_fetch,
//             flush_dec, mem_timeout, stall_count
interface pipeline_controller_if #(
  parameter int REG_ADDR_W  = 4,
  parameter int STALL_CNT_W = 16
);
  logic                   dec_valid;
  logic                   dec_ra_read;
  logic                   dec_rt_read;
  logic [REG_ADDR_W-1:0]  dec_ra_addr;
  logic [REG_ADDR_W-1:0]  dec_rt_addr;
  logic                   dec_ps_read;
  logic                   act_valid;
  logic                   act_reg_write;
  logic [REG_ADDR_W-1:0]  act_reg_addr;
  logic                   act_ps_write;
  logic                   act_mem_access;
  logic                   act_branch_taken;
  logic                   dc_miss;
  logic                   dc_done;

  logic                   fetch_stall;
  logic                   dec_stall;
  logic                   dec_bubble;
  logic                   act_stall;
  logic                   flush_fetch;
  logic                   flush_dec;
  logic                   mem_timeout;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output dec_valid, dec_ra_read, dec_rt_read, dec_ra_addr, dec_rt_addr,
           dec_ps_read, act_valid, act_reg_write, act_reg_addr, act_ps_write,
           act_mem_access, act_branch_taken, dc_miss, dc_done,
    input  fetch_stall, dec_stall, dec_bubble, act_stall, flush_fetch,
           flush_dec, mem_timeout, stall_count
  );

  modport slave (
    input  dec_valid, dec_ra_read, dec_rt_read, dec_ra_addr, dec_rt_addr,
           dec_ps_read, act_valid, act_reg_write, act_reg_addr, act_ps_write,
           act_mem_access, act_branch_taken, dc_miss, dc_done,
    output fetch_stall, dec_stall, dec_bubble, act_stall, flush_fetch,
           flush_dec, mem_timeout, stall_count
  );

endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// Purely combinational read-after-write hazard detection between the decode
// and action stages. No forwarding exists, so any match is a hazard; kept as
// its own block so forwarding can be added here later.
// Inputs : decode read enables/addresses, action write enables/address
// Output : raw - decode must wait one cycle for the action result
module hazard_detect #(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  dec_valid,
  input  logic                  dec_ra_read,
  input  logic                  dec_rt_read,
  input  logic [REG_ADDR_W-1:0] dec_ra_addr,
  input  logic [REG_ADDR_W-1:0] dec_rt_addr,
  input  logic                  dec_ps_read,
  input  logic                  act_valid,
  input  logic                  act_reg_write,
  input  logic [REG_ADDR_W-1:0] act_reg_addr,
  input  logic                  act_ps_write,
  output logic                  raw
);

  logic ra_hit;
  logic rt_hit;
  logic reg_hit;
  logic ps_hit;

  assign ra_hit  = dec_ra_read && (dec_ra_addr == act_reg_addr);
  assign rt_hit  = dec_rt_read && (dec_rt_addr == act_reg_addr);
  assign reg_hit = act_reg_write && (ra_hit || rt_hit);
  assign ps_hit  = dec_ps_read && act_ps_write;
  assign raw     = dec_valid && act_valid && (reg_hit || ps_hit);

endmodule

// File: rtl/pipeline_controller.sv
// Central hazard and sequencing controller for the pipelined NAND CPU.
// Produces per-stage stall, bubble and flush controls for RAW hazards,
// d-cache miss waits and taken-branch redirects.
// Ports:
//   clk   : clock, rising edge
//   n_rst : asynchronous active-low reset; all outputs read 0 while low
//   bus   : slave side of pipeline_controller_if (status in, controls out)
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int REG_ADDR_W  = 4,
  parameter int FETCH_LAT   = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int STALL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  pipeline_controller_if.slave bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_e              state;
  logic [WAIT_W-1:0]        wait_cnt;
  logic [WAIT_W-1:0]        wait_next;
  logic [2:0]               redir_cnt;
  logic                     timeout_q;
  logic [STALL_CNT_W-1:0]   stall_q;
  pipe_ctrl_t               ctrl;
  logic                     raw;
  logic                     mem_miss;
  logic                     branch;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .dec_valid     (bus.dec_valid),
    .dec_ra_read   (bus.dec_ra_read),
    .dec_rt_read   (bus.dec_rt_read),
    .dec_ra_addr   (bus.dec_ra_addr),
    .dec_rt_addr   (bus.dec_rt_addr),
    .dec_ps_read   (bus.dec_ps_read),
    .act_valid     (bus.act_valid),
    .act_reg_write (bus.act_reg_write),
    .act_reg_addr  (bus.act_reg_addr),
    .act_ps_write  (bus.act_ps_write),
    .raw           (raw)
  );

  // A miss outranks a branch, so an illegal miss+branch still waits on memory.
  assign mem_miss  = bus.act_valid && bus.act_mem_access && bus.dc_miss;
  assign branch    = bus.act_valid && bus.act_branch_taken;
  assign wait_next = wait_cnt + 1'b1;

  // Controls are combinational from state and inputs, gated by n_rst so the
  // glue sees all zeros for the whole reset window.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (n_rst) begin
      case (state)
        RUN: begin
          if (mem_miss) begin
            ctrl = ctrl_hold_all();
          end else if (branch) begin
            ctrl.flush_fetch = 1'b1;
            ctrl.flush_dec   = 1'b1;
          end else if (raw) begin
            ctrl.fetch_stall = 1'b1;
            ctrl.dec_stall   = 1'b1;
            ctrl.dec_bubble  = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!bus.dc_done) begin
            ctrl = ctrl_hold_all();
          end
        end
        REDIRECT: begin
          // Decode is empty while the new PC is fetched; RAW is irrelevant.
          ctrl.flush_dec = 1'b1;
        end
        HALT: begin
          ctrl = ctrl_hold_all();
        end
        default: begin
          ctrl = CTRL_IDLE;
        end
      endcase
    end
  end

  // Sequencing FSM plus wait, redirect and stall-statistics counters.
  // wait_cnt counts stalled cycles of the current miss, including the cycle
  // the miss was first seen.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      redir_cnt <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      if (ctrl.fetch_stall && (stall_q != {STALL_CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
      case (state)
        RUN: begin
          if (mem_miss) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else if (branch && (FETCH_LAT > 0)) begin
            state     <= REDIRECT;
            redir_cnt <= 3'(FETCH_LAT);
          end
        end
        MEM_WAIT: begin
          if (bus.dc_done) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_next;
            if (wait_next >= WAIT_W'(MEM_TIMEOUT)) begin
              state     <= HALT;
              timeout_q <= 1'b1;
            end
          end
        end
        REDIRECT: begin
          redir_cnt <= redir_cnt - 1'b1;
          if (redir_cnt == 3'd1) begin
            state <= RUN;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign bus.fetch_stall = ctrl.fetch_stall;
  assign bus.dec_stall   = ctrl.dec_stall;
  assign bus.dec_bubble  = ctrl.dec_bubble;
  assign bus.act_stall   = ctrl.act_stall;
  assign bus.flush_fetch = ctrl.flush_fetch;
  assign bus.flush_dec   = ctrl.flush_dec;
  assign bus.mem_timeout = timeout_q;
  assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller. Two instances share one input
// stream: dut0 with FETCH_LAT=2 and dut1 with FETCH_LAT=0. Directed sequences
// cover the listed scenarios, then randomized traffic runs against a
// cycle-level behavioural model.
module tb_pipeline_controller;

  localparam int REG_ADDR_W  = 4;
  localparam int MEM_TIMEOUT = 8;
  localparam int STALL_CNT_W = 16;
  localparam int LAT0        = 2;
  localparam int LAT1        = 0;
  localparam int SAT         = (1 << STALL_CNT_W) - 1;

  typedef struct packed {
    logic                  dec_valid;
    logic                  ra_read;
    logic                  rt_read;
    logic [REG_ADDR_W-1:0] ra_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic                  ps_read;
    logic                  act_valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic                  ps_write;
    logic                  mem_access;
    logic                  branch_taken;
    logic                  dc_miss;
    logic                  dc_done;
  } stim_t;

  // Model: how long the current miss has been stalling, how many redirect
  // bubbles remain, whether the core has given up on memory.
  typedef struct {
    int wait_age;
    int redir_left;
    bit halted;
    bit timeout;
    int stalls;
  } mdl_t;

  typedef struct {
    bit fs;
    bit ds;
    bit db;
    bit as;
    bit ff;
    bit fd;
  } exp_t;

  logic  clk = 1'b0;
  logic  n_rst = 1'b0;
  stim_t cur;
  mdl_t  m0;
  mdl_t  m1;
  int    checks = 0;
  int    errors = 0;
  int    fd_count0 = 0;
  int    fd_count1 = 0;

  always #5 clk = ~clk;

  pipeline_controller_if #(.REG_ADDR_W(REG_ADDR_W), .STALL_CNT_W(STALL_CNT_W)) bus0 ();
  pipeline_controller_if #(.REG_ADDR_W(REG_ADDR_W), .STALL_CNT_W(STALL_CNT_W)) bus1 ();

  assign bus1.dec_valid        = bus0.dec_valid;
  assign bus1.dec_ra_read      = bus0.dec_ra_read;
  assign bus1.dec_rt_read      = bus0.dec_rt_read;
  assign bus1.dec_ra_addr      = bus0.dec_ra_addr;
  assign bus1.dec_rt_addr      = bus0.dec_rt_addr;
  assign bus1.dec_ps_read      = bus0.dec_ps_read;
  assign bus1.act_valid        = bus0.act_valid;
  assign bus1.act_reg_write    = bus0.act_reg_write;
  assign bus1.act_reg_addr     = bus0.act_reg_addr;
  assign bus1.act_ps_write     = bus0.act_ps_write;
  assign bus1.act_mem_access   = bus0.act_mem_access;
  assign bus1.act_branch_taken = bus0.act_branch_taken;
  assign bus1.dc_miss          = bus0.dc_miss;
  assign bus1.dc_done          = bus0.dc_done;

  pipeline_controller #(
    .REG_ADDR_W(REG_ADDR_W), .FETCH_LAT(LAT0),
    .MEM_TIMEOUT(MEM_TIMEOUT), .STALL_CNT_W(STALL_CNT_W)
  ) dut0 (
    .clk(clk), .n_rst(n_rst), .bus(bus0.slave)
  );

  pipeline_controller #(
    .REG_ADDR_W(REG_ADDR_W), .FETCH_LAT(LAT1),
    .MEM_TIMEOUT(MEM_TIMEOUT), .STALL_CNT_W(STALL_CNT_W)
  ) dut1 (
    .clk(clk), .n_rst(n_rst), .bus(bus1.slave)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    if (obs !== 32'(expv)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    cur                   = s;
    bus0.dec_valid        = s.dec_valid;
    bus0.dec_ra_read      = s.ra_read;
    bus0.dec_rt_read      = s.rt_read;
    bus0.dec_ra_addr      = s.ra_addr;
    bus0.dec_rt_addr      = s.rt_addr;
    bus0.dec_ps_read      = s.ps_read;
    bus0.act_valid        = s.act_valid;
    bus0.act_reg_write    = s.reg_write;
    bus0.act_reg_addr     = s.reg_addr;
    bus0.act_ps_write     = s.ps_write;
    bus0.act_mem_access   = s.mem_access;
    bus0.act_branch_taken = s.branch_taken;
    bus0.dc_miss          = s.dc_miss;
    bus0.dc_done          = s.dc_done;
  endtask

  function automatic bit rawOf(input stim_t s);
    bit reg_match;
    reg_match = s.reg_write && ((s.ra_read && s.ra_addr == s.reg_addr) ||
                                (s.rt_read && s.rt_addr == s.reg_addr));
    return s.dec_valid && s.act_valid && (reg_match || (s.ps_read && s.ps_write));
  endfunction

  // One clock of behaviour: controls for this cycle and the model after the edge.
  function automatic void modelStep(input mdl_t m, input int lat, input stim_t s,
                                    output exp_t e, output mdl_t nm);
    e  = '{default: 0};
    nm = m;
    if (m.halted) begin
      e.fs = 1; e.ds = 1; e.as = 1;
    end else if (m.wait_age > 0) begin
      if (s.dc_done) begin
        nm.wait_age = 0;
      end else begin
        e.fs = 1; e.ds = 1; e.as = 1;
        nm.wait_age = m.wait_age + 1;
        if (nm.wait_age >= MEM_TIMEOUT) begin
          nm.halted   = 1;
          nm.timeout  = 1;
          nm.wait_age = 0;
        end
      end
    end else if (m.redir_left > 0) begin
      e.fd = 1;
      nm.redir_left = m.redir_left - 1;
    end else if (s.act_valid && s.mem_access && s.dc_miss) begin
      e.fs = 1; e.ds = 1; e.as = 1;
      nm.wait_age = 1;
    end else if (s.act_valid && s.branch_taken) begin
      e.ff = 1; e.fd = 1;
      nm.redir_left = lat;
    end else if (rawOf(s)) begin
      e.fs = 1; e.ds = 1; e.db = 1;
    end
    if (e.fs && m.stalls < SAT) nm.stalls = m.stalls + 1;
  endfunction

  task automatic checkSet(input string pfx, input exp_t e, input int mt, input int sc,
                          input logic [5:0] oc, input logic omt,
                          input logic [STALL_CNT_W-1:0] osc);
    checkOutput({pfx, "_fetch_stall"}, 32'(oc[5]), int'(e.fs));
    checkOutput({pfx, "_dec_stall"},   32'(oc[4]), int'(e.ds));
    checkOutput({pfx, "_dec_bubble"},  32'(oc[3]), int'(e.db));
    checkOutput({pfx, "_act_stall"},   32'(oc[2]), int'(e.as));
    checkOutput({pfx, "_flush_fetch"}, 32'(oc[1]), int'(e.ff));
    checkOutput({pfx, "_flush_dec"},   32'(oc[0]), int'(e.fd));
    checkOutput({pfx, "_mem_timeout"}, 32'(omt), mt);
    checkOutput({pfx, "_stall_count"}, 32'(osc), sc);
  endtask

  function automatic logic [5:0] ctrl0();
    return {bus0.fetch_stall, bus0.dec_stall, bus0.dec_bubble,
            bus0.act_stall, bus0.flush_fetch, bus0.flush_dec};
  endfunction

  function automatic logic [5:0] ctrl1();
    return {bus1.fetch_stall, bus1.dec_stall, bus1.dec_bubble,
            bus1.act_stall, bus1.flush_fetch, bus1.flush_dec};
  endfunction

  // Compare at the falling edge, advance the model, return just past the rising edge.
  task automatic cycle(input bit chk);
    exp_t e0, e1;
    mdl_t n0, n1;
    @(negedge clk);
    if (cur.act_valid && cur.mem_access && cur.dc_miss && cur.branch_taken)
      $display("[TB] assertion: illegal mem access with taken branch at %0t", $time);
    modelStep(m0, LAT0, cur, e0, n0);
    modelStep(m1, LAT1, cur, e1, n1);
    if (chk) begin
      checkSet("d0", e0, int'(m0.timeout), m0.stalls, ctrl0(), bus0.mem_timeout, bus0.stall_count);
      checkSet("d1", e1, int'(m1.timeout), m1.stalls, ctrl1(), bus1.mem_timeout, bus1.stall_count);
    end
    fd_count0 += int'(bus0.flush_dec);
    fd_count1 += int'(bus1.flush_dec);
    m0 = n0;
    m1 = n1;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic doReset();
    exp_t z;
    z = '{default: 0};
    n_rst = 1'b0;
    #1;
    checkSet("rst0", z, 0, 0, ctrl0(), bus0.mem_timeout, bus0.stall_count);
    checkSet("rst1", z, 0, 0, ctrl1(), bus1.mem_timeout, bus1.stall_count);
    applyStimulus('0);
    m0 = '{default: 0};
    m1 = '{default: 0};
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    applyStimulus('0);
    for (int i = 0; i < n; i++) cycle(1);
  endtask

  function automatic stim_t randomStim();
    stim_t s;
    s              = '0;
    s.dec_valid    = 1'($urandom_range(0, 3) != 0);
    s.ra_read      = 1'($urandom_range(0, 1));
    s.rt_read      = 1'($urandom_range(0, 1));
    s.ra_addr      = REG_ADDR_W'($urandom_range(0, 3));
    s.rt_addr      = REG_ADDR_W'($urandom_range(0, 3));
    s.ps_read      = 1'($urandom_range(0, 3) == 0);
    s.act_valid    = 1'($urandom_range(0, 3) != 0);
    s.reg_write    = 1'($urandom_range(0, 1));
    s.reg_addr     = REG_ADDR_W'($urandom_range(0, 3));
    s.ps_write     = 1'($urandom_range(0, 3) == 0);
    s.mem_access   = 1'($urandom_range(0, 3) == 0);
    s.branch_taken = !s.mem_access && ($urandom_range(0, 4) == 0);
    s.dc_miss      = 1'($urandom_range(0, 1));
    s.dc_done      = 1'($urandom_range(0, 2) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    applyStimulus('0);
    m0 = '{default: 0};
    m1 = '{default: 0};
    #2;
    doReset();

    // RAW on ra, on rt, and on program status: one stall cycle each.
    s = '0; s.act_valid = 1; s.reg_write = 1; s.reg_addr = 3;
    s.dec_valid = 1; s.ra_read = 1; s.ra_addr = 3;
    applyStimulus(s); cycle(1);
    s.act_valid = 0; applyStimulus(s); cycle(1);
    s = '0; s.act_valid = 1; s.reg_write = 1; s.reg_addr = 3;
    s.dec_valid = 1; s.rt_read = 1; s.rt_addr = 3;
    applyStimulus(s); cycle(1);
    s.act_valid = 0; applyStimulus(s); cycle(1);
    s = '0; s.act_valid = 1; s.ps_write = 1; s.dec_valid = 1; s.ps_read = 1;
    applyStimulus(s); cycle(1);
    s.act_valid = 0; applyStimulus(s); cycle(1);
    checkOutput("raw_stall_count", 32'(bus0.stall_count), 3);

    // Miss, five more waiting cycles, then completion.
    doReset();
    s = '0; s.act_valid = 1; s.mem_access = 1; s.dc_miss = 1;
    applyStimulus(s);
    for (int i = 0; i < 6; i++) cycle(1);
    s.dc_miss = 0; s.dc_done = 1; applyStimulus(s); cycle(1);
    idleCycles(2);
    checkOutput("mem_stall_count", 32'(bus0.stall_count), 6);

    // Taken branch: flush cycle plus FETCH_LAT bubble cycles.
    doReset();
    fd_count0 = 0; fd_count1 = 0;
    s = '0; s.act_valid = 1; s.branch_taken = 1;
    applyStimulus(s); cycle(1);
    idleCycles(4);
    checkOutput("redirect_flush_dec_cycles_lat2", 32'(fd_count0), 1 + LAT0);
    checkOutput("redirect_flush_dec_cycles_lat0", 32'(fd_count1), 1 + LAT1);

    // Branch and RAW together: flush wins, no bubble.
    s = '0; s.act_valid = 1; s.branch_taken = 1; s.reg_write = 1; s.reg_addr = 5;
    s.dec_valid = 1; s.ra_read = 1; s.ra_addr = 5;
    applyStimulus(s); cycle(1);
    idleCycles(3);

    // Illegal miss with branch: memory wait takes priority.
    s = '0; s.act_valid = 1; s.mem_access = 1; s.branch_taken = 1; s.dc_miss = 1;
    applyStimulus(s); cycle(1);
    s.branch_taken = 0; s.dc_miss = 0; s.dc_done = 1;
    applyStimulus(s); cycle(1);
    idleCycles(2);

    // Randomized traffic against the model.
    doReset();
    for (int i = 0; i < 600; i++) begin
      if (m0.halted || m1.halted) doReset();
      applyStimulus(randomStim());
      cycle(1);
    end

    // Reset in the middle of a memory wait.
    doReset();
    s = '0; s.act_valid = 1; s.mem_access = 1; s.dc_miss = 1;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) cycle(1);
    doReset();
    s = '0; s.act_valid = 1; s.branch_taken = 1;
    applyStimulus(s); cycle(1);
    idleCycles(3);

    // Timeout into HALT, then saturate the stall counter.
    doReset();
    s = '0; s.act_valid = 1; s.mem_access = 1; s.dc_miss = 1;
    applyStimulus(s);
    for (int i = 0; i < MEM_TIMEOUT + 3; i++) cycle(1);
    checkOutput("timeout_flag", 32'(bus0.mem_timeout), 1);
    checkOutput("halt_act_stall", 32'(bus0.act_stall), 1);
    s.dc_done = 1; applyStimulus(s); cycle(1);
    for (int i = 0; i < 70000; i++) cycle(0);
    cycle(1);
    checkOutput("stall_count_saturated0", 32'(bus0.stall_count), SAT);
    checkOutput("stall_count_saturated1", 32'(bus1.stall_count), SAT);
    doReset();
    idleCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
